ucsbece154b_dmem_arbiter: RTL and testbench
===========================================

// Module: ucsbece154b_dmem_arbiter
// PURPOSE
//  Shares the single-ported data memory between the two M-stage issue slots of the dual-issue pipeline.
//  When a bundle in M carries one or two loads/stores, the block serialises them in program order: slot 1 first, then slot 2.
//  It drives a req/ready handshake to a variable-latency memory and stalls the pipeline until the bundle's accesses complete.
//  Read data is latched per slot.
// PARAMETERS
//  DATA_WIDTH      32   data bus width
//  ADDR_WIDTH      32   address bus width
//  TIMEOUT_CYCLES  255  max wait cycles for mem_ready_i per access; 0 disables the watchdog
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  MemReqM_i      in   1   slot 1 in M is lw/sw (ResultSrcM==01 or MemWriteM)
//  MemWriteM_i    in   1   slot 1 access is a store
//  ALUResultM_i   in   AW  slot 1 byte address
//  WriteDataM_i   in   DW  slot 1 store data
//  ReadDataM_o    out  DW  slot 1 load data (registered)
//  MemReqM2_i     in   1   slot 2 in M is lw/sw
//  MemWriteM2_i   in   1   slot 2 access is a store
//  ALUResultM2_i  in   AW  slot 2 byte address
//  WriteDataM2_i  in   DW  slot 2 store data
//  ReadDataM2_o   out  DW  slot 2 load data (registered)
//  mem_req_o      out  1   memory request valid
//  mem_we_o       out  1   1 = write, 0 = read
//  mem_addr_o     out  AW  memory address
//  mem_wdata_o    out  DW  memory write data
//  mem_ready_i    in   1   memory accepted/completed the current request this cycle
//  mem_rdata_i    in   DW  read data, valid when mem_ready_i is 1
//  StallM_o       out  1   freeze PC, F/D, D/E and E/M registers
//  FlushW_o       out  1   insert a bubble into M/W (equal to StallM_o)
//  TimeoutErr_o   out  1   sticky watchdog error
// BEHAVIOUR
//  Reset (asynchronous, active-low)
//   - state=IDLE; all outputs 0, including both ReadData registers, mem_*_o and TimeoutErr_o.
//   - Reset mid-access abandons the access immediately; mem_req_o drops without waiting for ready.
//  FSM states: IDLE, ACC1, ACC2, DONE
//   - IDLE: MemReqM_i -> ACC1; else MemReqM2_i -> ACC2; else stay.
//   - ACC1: on mem_ready_i -> ACC2 if MemReqM2_i, else DONE.
//   - ACC2: on mem_ready_i -> DONE.
//   - DONE: -> IDLE unconditionally. This is the release cycle; requests are not sampled in DONE.
//  Stall and flush
//   - StallM_o = (IDLE & (MemReqM_i|MemReqM2_i)) | ACC1 | ACC2. Combinational; 0 in DONE.
//   - FlushW_o = StallM_o.
//  Memory interface
//   - mem_req_o=1 only in ACC1/ACC2.
//   - mem_we_o, mem_addr_o and mem_wdata_o are taken from the active slot's inputs, which are stable because M is stalled.
//   - Fields must not change while mem_req_o=1 and mem_ready_i=0.
//   - mem_ready_i is ignored in IDLE/DONE.
//  Read data
//   - On mem_ready_i in ACCn with a read: ReadDataMn_o <= mem_rdata_i.
//   - Stores leave the slot's register unchanged.
//   - Values are valid in DONE and held until the next capture.
//  Latency
//   - With zero-wait memory: 1 access = 2 stall cycles; 2 accesses = 3 stall cycles.
//   - Each wait cycle adds 1.
//  Ordering: slot 1 always completes before slot 2 starts, so a same-address sw(slot1) then lw(slot2) returns the new data.
//  Watchdog
//   - A counter of consecutive ACCn cycles with mem_ready_i=0 clears on state entry and on ready.
//   - When it reaches TIMEOUT_CYCLES (if nonzero): TimeoutErr_o<=1 (sticky until reset).
//   - The access is abandoned as if ready arrived, and a read captures 0.
//   - With TIMEOUT_CYCLES=0 the block waits indefinitely.
// TESTING
//  - Slot1 lw addr 0x10, mem returns 0xCAFE0001 with ready in the 1st ACC1 cycle -> StallM_o high 2 cycles; ReadDataM_o=0xCAFE0001 in DONE.
//  - Both slots: slot1 sw 0x20<=0x55, slot2 lw 0x20, model memory -> order: write, then read; ReadDataM2_o=0x55; 3 stall cycles.
//  - Slot2-only lw, memory ready after 4 wait cycles -> IDLE->ACC2 directly; mem fields held stable; 6 stall cycles total.
//  - TIMEOUT_CYCLES=8, ready never asserted -> TimeoutErr_o=1 after 8 ACC1 cycles; FSM reaches DONE; ReadDataM_o=0; error stays set.
//  - Assert reset low in ACC2 -> mem_req_o, StallM_o and TimeoutErr_o drop to 0 asynchronously; state IDLE after release.
//  - Back-to-back bundles, each with one lw -> DONE releases one cycle; the new bundle is stalled the next cycle; no request is serviced twice.

Source files
------------

// File: rtl/ucsbece154b_dmem_arbiter.sv
// Data-memory arbiter for the dual-issue M stage.
// Serialises up to two loads/stores per bundle onto one req/ready memory
// port (slot 1 first, then slot 2) and stalls the pipeline until the
// bundle's accesses are finished. A watchdog abandons accesses that never
// see ready and raises a sticky error.
module ucsbece154b_dmem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemReqM_i,
  input  logic                  MemWriteM_i,
  input  logic [ADDR_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  output logic [DATA_WIDTH-1:0] ReadDataM_o,
  input  logic                  MemReqM2_i,
  input  logic                  MemWriteM2_i,
  input  logic [ADDR_WIDTH-1:0] ALUResultM2_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM2_i,
  output logic [DATA_WIDTH-1:0] ReadDataM2_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  StallM_o,
  output logic                  FlushW_o,
  output logic                  TimeoutErr_o
);

  // The counter only ever needs to hold TIMEOUT_CYCLES-1 before it fires.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic             inAcc;
  logic             timeoutHit;
  logic             accDone;

  assign inAcc = (state == ACC1) || (state == ACC2);

  // A timeout behaves like a ready that carries no data; a real ready
  // arriving on the last allowed cycle still wins.
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && inAcc && !mem_ready_i &&
                      (waitCnt == CNT_LAST);
  assign accDone    = inAcc && (mem_ready_i || timeoutHit);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state, memory request fields and pipeline stall.
  always_comb begin
    stateNext   = state;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      IDLE: begin
        if (MemReqM_i) begin
          stateNext = ACC1;
        end else if (MemReqM2_i) begin
          stateNext = ACC2;
        end
      end
      ACC1: begin
        mem_req_o   = 1'b1;
        mem_we_o    = MemWriteM_i;
        mem_addr_o  = ALUResultM_i;
        mem_wdata_o = WriteDataM_i;
        if (accDone) begin
          stateNext = MemReqM2_i ? ACC2 : DONE;
        end
      end
      ACC2: begin
        mem_req_o   = 1'b1;
        mem_we_o    = MemWriteM2_i;
        mem_addr_o  = ALUResultM2_i;
        mem_wdata_o = WriteDataM2_i;
        if (accDone) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    // Gated by reset so the stall drops immediately while reset is held,
    // even if the M-stage request inputs are still asserted.
    StallM_o = reset & (((state == IDLE) & (MemReqM_i | MemReqM2_i)) | inAcc);
    FlushW_o = StallM_o;
  end

  // Consecutive not-ready cycles of the current access; restarts on every
  // new access and on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (!inAcc || accDone) begin
      waitCnt <= '0;
    end else begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  // Slot 1 load data: captured when its read completes, zero on timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadDataM_o <= '0;
    end else if ((state == ACC1) && accDone && !MemWriteM_i) begin
      ReadDataM_o <= timeoutHit ? '0 : mem_rdata_i;
    end
  end

  // Slot 2 load data: captured when its read completes, zero on timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadDataM2_o <= '0;
    end else if ((state == ACC2) && accDone && !MemWriteM2_i) begin
      ReadDataM2_o <= timeoutHit ? '0 : mem_rdata_i;
    end
  end

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      TimeoutErr_o <= 1'b0;
    end else if (timeoutHit) begin
      TimeoutErr_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ucsbece154b_dmem_arbiter.sv
// Testbench for ucsbece154b_dmem_arbiter: a variable-latency memory
// responder plus a bundle-level reference model of stall length, access
// order, load results and the watchdog flag.
module tb_ucsbece154b_dmem_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic        memReq1, memWrite1, memReq2, memWrite2;
  logic [31:0] addr1, wdata1, addr2, wdata2;
  logic [31:0] rd1, rd2;
  logic        memReqO, memWeO, memReady;
  logic [31:0] memAddrO, memWdataO, memRdata;
  logic        stallM, flushW, timeoutErr;

  always #5 clk = ~clk;

  ucsbece154b_dmem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(rstN),
    .MemReqM_i(memReq1), .MemWriteM_i(memWrite1),
    .ALUResultM_i(addr1), .WriteDataM_i(wdata1), .ReadDataM_o(rd1),
    .MemReqM2_i(memReq2), .MemWriteM2_i(memWrite2),
    .ALUResultM2_i(addr2), .WriteDataM2_i(wdata2), .ReadDataM2_o(rd2),
    .mem_req_o(memReqO), .mem_we_o(memWeO), .mem_addr_o(memAddrO),
    .mem_wdata_o(memWdataO), .mem_ready_i(memReady), .mem_rdata_i(memRdata),
    .StallM_o(stallM), .FlushW_o(flushW), .TimeoutErr_o(timeoutErr)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } accT;

  int          tests = 0;
  int          fails = 0;
  accT         actLog[$];
  accT         expLog[$];
  int          waitQ[$];
  logic [31:0] bfmMem [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];
  logic [31:0] expRd1 = '0;
  logic [31:0] expRd2 = '0;
  logic        expErr = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return a ^ 32'hA5A5_0001;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  // Memory responder: each new request pops its wait count; ready is
  // raised after that many cycles. Fields must hold for the whole access.
  int  bfmCnt;
  int  bfmWait;
  bit  bfmBusy = 0;
  accT bfmCur;
  always @(negedge clk) begin
    memReady = 1'b0;
    memRdata = $urandom;
    if (!memReqO) begin
      bfmBusy = 0;
    end else begin
      if (!bfmBusy) begin
        bfmBusy = 1;
        bfmCnt  = 0;
        bfmWait = (waitQ.size() > 0) ? waitQ.pop_front() : 0;
        bfmCur  = '{we: memWeO, addr: memAddrO, data: memWdataO};
        actLog.push_back(bfmCur);
      end else begin
        check("memWeStable", 64'(memWeO), 64'(bfmCur.we));
        check("memAddrStable", 64'(memAddrO), 64'(bfmCur.addr));
        check("memWdataStable", 64'(memWdataO), 64'(bfmCur.data));
      end
      if (bfmCnt == bfmWait) begin
        memReady = 1'b1;
        if (bfmCur.we) bfmMem[bfmCur.addr] = bfmCur.data;
        else memRdata = bfmMem.exists(bfmCur.addr) ? bfmMem[bfmCur.addr] : initWord(bfmCur.addr);
        bfmBusy = 0;
      end else if (bfmCnt == T - 1) begin
        bfmBusy = 0;
      end
      bfmCnt++;
    end
  end

  function automatic int accCycles(input int w);
    return (w >= T) ? T : w + 1;
  endfunction

  // Applies one bundle in the IDLE cycle, counts stall cycles until the
  // release cycle and compares everything against the reference model.
  task automatic runBundle(input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                           input logic r2, input logic w2, input logic [31:0] a2, input logic [31:0] d2,
                           input int wt1, input int wt2, input string tag);
    int  expStall = 0;
    int  stalls = 0;
    int  cyc = 0;
    bit  done = 0;
    bit  to;
    expLog.delete();
    if (r1) begin
      expStall += accCycles(wt1);
      expLog.push_back('{we: w1, addr: a1, data: d1});
      to = (wt1 >= T);
      if (to) expErr = 1'b1;
      if (!w1) expRd1 = to ? 32'h0 : refRead(a1);
      else if (!to) refMem[a1] = d1;
    end
    if (r2) begin
      expStall += accCycles(wt2);
      expLog.push_back('{we: w2, addr: a2, data: d2});
      to = (wt2 >= T);
      if (to) expErr = 1'b1;
      if (!w2) expRd2 = to ? 32'h0 : refRead(a2);
      else if (!to) refMem[a2] = d2;
    end
    if (r1 || r2) expStall += 1;

    @(posedge clk); #1;
    actLog.delete();
    if (r1) waitQ.push_back(wt1);
    if (r2) waitQ.push_back(wt2);
    memReq1 = r1; memWrite1 = w1; addr1 = a1; wdata1 = d1;
    memReq2 = r2; memWrite2 = w2; addr2 = a2; wdata2 = d2;
    while (!done && cyc < 100) begin
      #1;
      check({tag, ":flushEqStall"}, 64'(flushW), 64'(stallM));
      if (stallM) begin
        stalls++;
        @(posedge clk); #1;
      end else begin
        done = 1;
      end
      cyc++;
    end
    check({tag, ":releaseWithinBound"}, 64'(done), 64'd1);
    check({tag, ":stallCycles"}, 64'(stalls), 64'(expStall));
    check({tag, ":rd1"}, 64'(rd1), 64'(expRd1));
    check({tag, ":rd2"}, 64'(rd2), 64'(expRd2));
    check({tag, ":timeoutErr"}, 64'(timeoutErr), 64'(expErr));
    check({tag, ":reqLowAtRelease"}, 64'(memReqO), 64'd0);
    check({tag, ":accessCount"}, 64'(actLog.size()), 64'(expLog.size()));
    for (int i = 0; i < expLog.size() && i < actLog.size(); i++) begin
      check({tag, ":accWe"}, 64'(actLog[i].we), 64'(expLog[i].we));
      check({tag, ":accAddr"}, 64'(actLog[i].addr), 64'(expLog[i].addr));
      check({tag, ":accData"}, 64'(actLog[i].data), 64'(expLog[i].data));
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    memReq1 = 1'b0; memReq2 = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check("idleNoStall", 64'(stallM), 64'd0);
      check("idleNoReq", 64'(memReqO), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL globalTimeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic        rr1, rr2, ww1, ww2;
    logic [31:0] ra1, ra2;
    rstN = 1'b0;
    memReady = 1'b0; memRdata = '0;
    memReq1 = 1'b1; memWrite1 = 1'b0; addr1 = 32'h10; wdata1 = '0;
    memReq2 = 1'b1; memWrite2 = 1'b0; addr2 = 32'h14; wdata2 = '0;
    #12;
    check("rst:stall", 64'(stallM), 64'd0);
    check("rst:flush", 64'(flushW), 64'd0);
    check("rst:req", 64'(memReqO), 64'd0);
    check("rst:we", 64'(memWeO), 64'd0);
    check("rst:addr", 64'(memAddrO), 64'd0);
    check("rst:wdata", 64'(memWdataO), 64'd0);
    check("rst:rd1", 64'(rd1), 64'd0);
    check("rst:rd2", 64'(rd2), 64'd0);
    check("rst:err", 64'(timeoutErr), 64'd0);
    memReq1 = 1'b0; memReq2 = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;

    // Single slot-1 load, zero wait.
    bfmMem[32'h10] = 32'hCAFE0001; refMem[32'h10] = 32'hCAFE0001;
    runBundle(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, "lw1");
    idle(1);
    // Store then load to the same address inside one bundle.
    runBundle(1, 1, 32'h20, 32'h55, 1, 0, 32'h20, 32'h0, 0, 0, "swlw");
    idle(2);
    // Slot-2-only load with four wait cycles.
    runBundle(0, 0, 32'h0, 32'h0, 1, 0, 32'h30, 32'h0, 0, 4, "lw2wait");
    // Ready on the last cycle before the watchdog would fire.
    runBundle(1, 0, 32'h34, 32'h0, 0, 0, 32'h0, 32'h0, T - 1, 0, "edgeWait");
    // Back-to-back single-load bundles with the old bundle held during release.
    runBundle(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, "b2bA");
    runBundle(0, 0, 32'h0, 32'h0, 1, 0, 32'h44, 32'h0, 1, 0, "b2bB");
    runBundle(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, "b2bC");
    // Bundle without memory operations must not stall.
    runBundle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, "noMem");

    for (int i = 0; i < 40; i++) begin
      rr1 = 1'($urandom_range(0, 1)); rr2 = 1'($urandom_range(0, 1));
      ww1 = 1'($urandom_range(0, 1)); ww2 = 1'($urandom_range(0, 1));
      ra1 = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      ra2 = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      runBundle(rr1, ww1, ra1, $urandom, rr2, ww2, ra2, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), "rand");
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // Ensure slot 1 holds nonzero data, then let its next load time out.
    runBundle(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, "preTimeout");
    runBundle(1, 0, 32'h48, 32'h0, 0, 0, 32'h0, 32'h0, 1000, 0, "timeout");
    runBundle(0, 0, 32'h0, 32'h0, 1, 1, 32'h4C, 32'h77, 0, 0, "afterTimeout");

    // Reset while the slot-2 access is outstanding.
    @(posedge clk); #1;
    waitQ.push_back(0); waitQ.push_back(50);
    memReq1 = 1'b1; memWrite1 = 1'b0; addr1 = 32'h10;
    memReq2 = 1'b1; memWrite2 = 1'b0; addr2 = 32'h50;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("acc2:req", 64'(memReqO), 64'd1);
    check("acc2:addr", 64'(memAddrO), 64'h50);
    #2 rstN = 1'b0;
    #1;
    check("midRst:req", 64'(memReqO), 64'd0);
    check("midRst:stall", 64'(stallM), 64'd0);
    check("midRst:err", 64'(timeoutErr), 64'd0);
    check("midRst:rd1", 64'(rd1), 64'd0);
    check("midRst:addr", 64'(memAddrO), 64'd0);
    @(posedge clk); #1;
    waitQ.delete();
    memReq1 = 1'b0; memReq2 = 1'b0;
    expRd1 = '0; expRd2 = '0; expErr = 1'b0;
    rstN = 1'b1;
    #1;
    check("postRst:stall", 64'(stallM), 64'd0);
    check("postRst:req", 64'(memReqO), 64'd0);
    runBundle(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, "postRst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
